// File: rtl/swd_target_phy.sv
// SWD target PHY: oversamples the host SWDCLK/SWDIO in the PHY_CLK domain, decodes requests,
// drives ACK and read data, and captures write data with a parity check.
module swd_target_phy #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_ONES    = 50,
    parameter int TRN         = 1
) (
    input  logic        PHY_CLK,
    input  logic        RESETn,
    input  logic        ENABLE,
    input  logic        SWDCLK,
    input  logic        SWDIN,
    output logic        SWDOUT,
    output logic        SWDOE,
    output logic        REQ_VALID,
    output logic        REQ_APNDP,
    output logic        REQ_RNW,
    output logic [1:0]  REQ_ADDR,
    input  logic [2:0]  ACK_IN,
    input  logic [31:0] RDATA,
    output logic [31:0] WDATA,
    output logic        WDATA_VALID,
    output logic        WDATA_PERR,
    output logic        LINE_RESET,
    output logic        PROTO_ERR
);
    localparam int OW = $clog2(RST_ONES + 1);

    typedef enum logic [2:0] {
        S_LOCKOUT, S_IDLE, S_REQ, S_TRN1, S_ACK, S_RDATA, S_TRN2, S_WDATA
    } state_t;

    logic active;
    assign active = RESETn & ENABLE;

    logic [SYNC_STAGES-1:0] clk_sync_reg, din_sync_reg;
    logic                   clk_prev_reg;
    logic                   clk_s, din_s, rise;

    always_ff @(posedge PHY_CLK) begin
        if (!active) begin
            clk_sync_reg <= '0;
            din_sync_reg <= '0;
            clk_prev_reg <= 1'b0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], SWDCLK};
            din_sync_reg <= {din_sync_reg[SYNC_STAGES-2:0], SWDIN};
            clk_prev_reg <= clk_s;
        end
    end

    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign din_s = din_sync_reg[SYNC_STAGES-1];
    assign rise  = clk_s & ~clk_prev_reg;

    state_t      state_reg, state_next;
    logic [5:0]  bit_cnt_reg, bit_cnt_next;
    logic [OW-1:0] ones_reg, ones_next;
    logic [6:0]  req_sh_reg, req_sh_next, req_word;
    logic [2:0]  ack_reg, ack_next;
    logic [31:0] rdata_sh_reg, rdata_sh_next;
    logic        rpar_reg, rpar_next;
    logic [31:0] wdata_sh_reg, wdata_sh_next;
    logic        wr_after_reg, wr_after_next;
    logic        swdout_reg, swdout_next, swdoe_reg, swdoe_next;
    logic        req_valid_reg, req_valid_next, req_apndp_reg, req_apndp_next;
    logic        req_rnw_reg, req_rnw_next;
    logic [1:0]  req_addr_reg, req_addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        wdata_valid_reg, wdata_valid_next, wdata_perr_reg, wdata_perr_next;
    logic        line_reset_reg, line_reset_next, proto_err_reg, proto_err_next;

    // Request bits shift in LSB first: [0]=APnDP [1]=RnW [2]=A2 [3]=A3 [4]=parity [5]=stop [6]=park
    assign req_word = {din_s, req_sh_reg[6:1]};

    always_ff @(posedge PHY_CLK) begin
        if (!active) begin
            state_reg       <= S_LOCKOUT;
            bit_cnt_reg     <= '0;
            ones_reg        <= '0;
            req_sh_reg      <= '0;
            ack_reg         <= '0;
            rdata_sh_reg    <= '0;
            rpar_reg        <= 1'b0;
            wdata_sh_reg    <= '0;
            wr_after_reg    <= 1'b0;
            swdout_reg      <= 1'b0;
            swdoe_reg       <= 1'b0;
            req_valid_reg   <= 1'b0;
            req_apndp_reg   <= 1'b0;
            req_rnw_reg     <= 1'b0;
            req_addr_reg    <= '0;
            wdata_reg       <= '0;
            wdata_valid_reg <= 1'b0;
            wdata_perr_reg  <= 1'b0;
            line_reset_reg  <= 1'b0;
            proto_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            ones_reg        <= ones_next;
            req_sh_reg      <= req_sh_next;
            ack_reg         <= ack_next;
            rdata_sh_reg    <= rdata_sh_next;
            rpar_reg        <= rpar_next;
            wdata_sh_reg    <= wdata_sh_next;
            wr_after_reg    <= wr_after_next;
            swdout_reg      <= swdout_next;
            swdoe_reg       <= swdoe_next;
            req_valid_reg   <= req_valid_next;
            req_apndp_reg   <= req_apndp_next;
            req_rnw_reg     <= req_rnw_next;
            req_addr_reg    <= req_addr_next;
            wdata_reg       <= wdata_next;
            wdata_valid_reg <= wdata_valid_next;
            wdata_perr_reg  <= wdata_perr_next;
            line_reset_reg  <= line_reset_next;
            proto_err_reg   <= proto_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        ones_next        = ones_reg;
        req_sh_next      = req_sh_reg;
        ack_next         = ack_reg;
        rdata_sh_next    = rdata_sh_reg;
        rpar_next        = rpar_reg;
        wdata_sh_next    = wdata_sh_reg;
        wr_after_next    = wr_after_reg;
        swdout_next      = swdout_reg;
        swdoe_next       = swdoe_reg;
        req_valid_next   = 1'b0;
        req_apndp_next   = req_apndp_reg;
        req_rnw_next     = req_rnw_reg;
        req_addr_next    = req_addr_reg;
        wdata_next       = wdata_reg;
        wdata_valid_next = 1'b0;
        wdata_perr_next  = wdata_perr_reg;
        line_reset_next  = 1'b0;
        proto_err_next   = 1'b0;

        if (rise) begin
            // Only host-driven bits count towards a line reset
            if (!swdoe_reg) begin
                if (!din_s)
                    ones_next = '0;
                else if (ones_reg < OW'(RST_ONES))
                    ones_next = ones_reg + 1'b1;
            end

            case (state_reg)
                S_LOCKOUT: begin
                    if (!din_s && ones_reg >= OW'(RST_ONES))
                        state_next = S_IDLE;
                end
                S_IDLE: begin
                    if (din_s) begin
                        state_next   = S_REQ;
                        bit_cnt_next = 6'd1;
                    end
                end
                S_REQ: begin
                    req_sh_next  = req_word;
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                    if (bit_cnt_reg == 6'd7) begin
                        bit_cnt_next = '0;
                        if (req_word[4] == ^req_word[3:0] && !req_word[5] && req_word[6]) begin
                            req_valid_next = 1'b1;
                            req_apndp_next = req_word[0];
                            req_rnw_next   = req_word[1];
                            req_addr_next  = {req_word[3], req_word[2]};
                            state_next     = S_TRN1;
                        end else begin
                            proto_err_next = 1'b1;
                            state_next     = S_LOCKOUT;
                        end
                    end
                end
                S_TRN1: begin
                    if (bit_cnt_reg == 6'(TRN - 1)) begin
                        ack_next      = ACK_IN;
                        rdata_sh_next = RDATA;
                        rpar_next     = ^RDATA;
                        swdout_next   = ACK_IN[0];
                        swdoe_next    = 1'b1;
                        bit_cnt_next  = '0;
                        state_next    = S_ACK;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end
                S_ACK: begin
                    if (bit_cnt_reg == 6'd0) begin
                        swdout_next  = ack_reg[1];
                        bit_cnt_next = 6'd1;
                    end else begin
                        swdout_next  = ack_reg[2];
                        bit_cnt_next = '0;
                        if (ack_reg == 3'b001 && req_rnw_reg) begin
                            state_next = S_RDATA;
                        end else begin
                            wr_after_next = (ack_reg == 3'b001);
                            state_next    = S_TRN2;
                        end
                    end
                end
                S_RDATA: begin
                    if (bit_cnt_reg == 6'd32) begin
                        swdout_next   = rpar_reg;
                        wr_after_next = 1'b0;
                        bit_cnt_next  = '0;
                        state_next    = S_TRN2;
                    end else begin
                        swdout_next   = rdata_sh_reg[0];
                        rdata_sh_next = {1'b0, rdata_sh_reg[31:1]};
                        bit_cnt_next  = bit_cnt_reg + 6'd1;
                    end
                end
                S_TRN2: begin
                    swdoe_next  = 1'b0;
                    swdout_next = 1'b0;
                    if (bit_cnt_reg == 6'(TRN - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = wr_after_reg ? S_WDATA : S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end
                S_WDATA: begin
                    if (bit_cnt_reg == 6'd32) begin
                        wdata_next       = wdata_sh_reg;
                        wdata_perr_next  = (^wdata_sh_reg) ^ din_s;
                        wdata_valid_next = 1'b1;
                        bit_cnt_next     = '0;
                        state_next       = S_IDLE;
                    end else begin
                        wdata_sh_next = {din_s, wdata_sh_reg[31:1]};
                        bit_cnt_next  = bit_cnt_reg + 6'd1;
                    end
                end
                default: state_next = S_LOCKOUT;
            endcase

            // Line reset wins over whatever the state machine decided this rise
            if (!swdoe_reg && din_s && ones_reg == OW'(RST_ONES - 1)) begin
                line_reset_next = 1'b1;
                state_next      = S_LOCKOUT;
                swdoe_next      = 1'b0;
                swdout_next     = 1'b0;
                bit_cnt_next    = '0;
            end
        end
    end

    assign SWDOUT      = swdout_reg;
    assign SWDOE       = swdoe_reg;
    assign REQ_VALID   = req_valid_reg;
    assign REQ_APNDP   = req_apndp_reg;
    assign REQ_RNW     = req_rnw_reg;
    assign REQ_ADDR    = req_addr_reg;
    assign WDATA       = wdata_reg;
    assign WDATA_VALID = wdata_valid_reg;
    assign WDATA_PERR  = wdata_perr_reg;
    assign LINE_RESET  = line_reset_reg;
    assign PROTO_ERR   = proto_err_reg;
endmodule

// File: tb/tb_swd_target_phy.sv
// Directed bench for swd_target_phy: acts as the SWD host, driving SWDCLK/SWDIN bit by bit.
module tb_swd_target_phy;
    logic        PHY_CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        ENABLE = 1'b1;
    logic        SWDCLK = 1'b0;
    logic        SWDIN = 1'b0;
    logic        SWDOUT, SWDOE, REQ_VALID, REQ_APNDP, REQ_RNW;
    logic [1:0]  REQ_ADDR;
    logic [2:0]  ACK_IN = 3'b000;
    logic [31:0] RDATA = 32'h0;
    logic [31:0] WDATA;
    logic        WDATA_VALID, WDATA_PERR, LINE_RESET, PROTO_ERR;

    swd_target_phy dut (
        .PHY_CLK(PHY_CLK), .RESETn(RESETn), .ENABLE(ENABLE),
        .SWDCLK(SWDCLK), .SWDIN(SWDIN), .SWDOUT(SWDOUT), .SWDOE(SWDOE),
        .REQ_VALID(REQ_VALID), .REQ_APNDP(REQ_APNDP), .REQ_RNW(REQ_RNW), .REQ_ADDR(REQ_ADDR),
        .ACK_IN(ACK_IN), .RDATA(RDATA), .WDATA(WDATA), .WDATA_VALID(WDATA_VALID),
        .WDATA_PERR(WDATA_PERR), .LINE_RESET(LINE_RESET), .PROTO_ERR(PROTO_ERR)
    );

    always #5 PHY_CLK = ~PHY_CLK;

    int checks = 0;
    int errors = 0;
    int lr_cnt = 0, rv_cnt = 0, pe_cnt = 0, wv_cnt = 0, oe_cnt = 0;
    logic last_perr = 1'b0;

    always @(posedge PHY_CLK) begin
        if (LINE_RESET)  lr_cnt <= lr_cnt + 1;
        if (REQ_VALID)   rv_cnt <= rv_cnt + 1;
        if (PROTO_ERR)   pe_cnt <= pe_cnt + 1;
        if (WDATA_VALID) begin
            wv_cnt    <= wv_cnt + 1;
            last_perr <= WDATA_PERR;
        end
        if (SWDOE)       oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // One SWDCLK period; target outputs are sampled late in the high phase.
    task automatic swd_bit(input logic din, output logic dout, output logic oe);
        @(negedge PHY_CLK);
        SWDIN = din;
        repeat (3) @(negedge PHY_CLK);
        SWDCLK = 1'b1;
        repeat (6) @(negedge PHY_CLK);
        dout = SWDOUT;
        oe   = SWDOE;
        SWDCLK = 1'b0;
        repeat (2) @(negedge PHY_CLK);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        logic d, o;
        for (int i = 0; i < n; i++) swd_bit(v[i], d, o);
    endtask

    task automatic line_reset();
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 50);
        send_bits(64'h0, 2);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  req;
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic        wpar;
        logic        exp_apndp;
        logic        exp_rnw;
        logic [1:0]  exp_addr;
        logic        exp_rpar;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[6];

    task automatic run_txn(input vec_t v);
        int   rv0, wv0;
        logic d, o, oe_all;
        logic [2:0]  got_ack;
        logic [32:0] got_rd;
        rv0 = rv_cnt;
        wv0 = wv_cnt;
        ACK_IN = v.ack;
        RDATA  = v.rdata;
        send_bits({56'h0, v.req}, 8);
        check({v.name, "_req_valid"}, 32'(rv_cnt - rv0), 32'd1);
        check({v.name, "_req_fields"}, {27'h0, REQ_APNDP, REQ_RNW, 1'b0, REQ_ADDR},
              {27'h0, v.exp_apndp, v.exp_rnw, 1'b0, v.exp_addr});
        oe_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
            swd_bit(1'b0, d, o);
            got_ack[i] = d;
            oe_all = oe_all & o;
        end
        check({v.name, "_ack"}, {28'h0, oe_all, got_ack}, {28'h1, v.ack});
        if (v.ack == 3'b001 && v.exp_rnw) begin
            oe_all = 1'b1;
            for (int i = 0; i < 33; i++) begin
                swd_bit(1'b0, d, o);
                got_rd[i] = d;
                oe_all = oe_all & o;
            end
            check({v.name, "_rdata"}, got_rd[31:0], v.rdata);
            check({v.name, "_rpar_oe"}, {30'h0, oe_all, got_rd[32]}, {30'h0, 1'b1, v.exp_rpar});
        end
        swd_bit(1'b0, d, o);
        check({v.name, "_trn2_release"}, {31'h0, o}, 32'h0);
        if (v.ack == 3'b001 && !v.exp_rnw) begin
            send_bits({31'h0, v.wpar, v.wdata}, 33);
            check({v.name, "_wvalid"}, 32'(wv_cnt - wv0), 32'd1);
            check({v.name, "_wdata"}, WDATA, v.wdata);
            check({v.name, "_perr"}, {31'h0, last_perr}, {31'h0, v.exp_perr});
        end else begin
            check({v.name, "_no_wvalid"}, 32'(wv_cnt - wv0), 32'd0);
        end
        send_bits(64'h0, 2);
    endtask

    initial begin
        int lr0, rv0, pe0, oe0, wv0;
        logic d, o;

        vecs[0] = '{"rd_dp0",   8'hA5, 3'b001, 32'h0BC11477, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{"wr_dp0",   8'h81, 3'b001, 32'h0,        32'h12345678, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{"wr_badpar",8'h81, 3'b001, 32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        vecs[3] = '{"rd_wait",  8'hA5, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[4] = '{"rd_ap3",   8'h9F, 3'b001, 32'h00000007, 32'h0,        1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[5] = '{"wr_ap1_flt",8'h8B,3'b100, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};

        repeat (5) @(negedge PHY_CLK);
        check("rst_outputs", {28'h0, SWDOE, SWDOUT, REQ_VALID, LINE_RESET}, 32'h0);
        check("rst_wdata", WDATA, 32'h0);
        check("rst_req", {29'h0, REQ_APNDP, REQ_ADDR}, 32'h0);
        RESETn = 1'b1;
        repeat (3) @(negedge PHY_CLK);

        // Line reset: pulse lands exactly on the 50th one
        lr0 = lr_cnt;
        oe0 = oe_cnt;
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 49);
        check("lr_before_50", 32'(lr_cnt - lr0), 32'd0);
        send_bits(64'h1, 1);
        check("lr_at_50", 32'(lr_cnt - lr0), 32'd1);
        send_bits(64'h0, 2);
        check("lr_single", 32'(lr_cnt - lr0), 32'd1);
        check("lr_no_oe", 32'(oe_cnt - oe0), 32'd0);

        pe0 = pe_cnt;
        foreach (vecs[i]) run_txn(vecs[i]);
        check("no_proto_err", 32'(pe_cnt - pe0), 32'd0);

        // Bad request parity locks the target out until a line reset
        pe0 = pe_cnt;
        rv0 = rv_cnt;
        oe0 = oe_cnt;
        send_bits(64'h85, 8);
        check("bad_par_proto", 32'(pe_cnt - pe0), 32'd1);
        send_bits(64'hA5, 8);
        send_bits(64'h0, 40);
        check("lockout_no_req", 32'(rv_cnt - rv0), 32'd0);
        check("lockout_no_oe", 32'(oe_cnt - oe0), 32'd0);
        line_reset();
        run_txn(vecs[0]);

        // Reset during data bit 10 of a read
        ACK_IN = 3'b001;
        RDATA  = 32'h0BC11477;
        send_bits(64'hA5, 8);
        send_bits(64'h0, 3 + 10);
        @(negedge PHY_CLK);
        SWDIN = 1'b0;
        repeat (3) @(negedge PHY_CLK);
        SWDCLK = 1'b1;
        repeat (6) @(negedge PHY_CLK);
        check("oe_before_rst", {31'h0, SWDOE}, 32'h1);
        lr0 = lr_cnt; rv0 = rv_cnt; pe0 = pe_cnt; wv0 = wv_cnt;
        RESETn = 1'b0;
        @(posedge PHY_CLK);
        #1;
        check("oe_drop_on_rst", {31'h0, SWDOE}, 32'h0);
        SWDCLK = 1'b0;
        repeat (4) @(negedge PHY_CLK);
        RESETn = 1'b1;
        repeat (2) @(negedge PHY_CLK);
        check("rst_no_pulses", 32'((lr_cnt - lr0) + (rv_cnt - rv0) + (pe_cnt - pe0) + (wv_cnt - wv0)), 32'd0);
        rv0 = rv_cnt;
        oe0 = oe_cnt;
        send_bits(64'hA5, 8);
        swd_bit(1'b0, d, o);
        send_bits(64'h0, 4);
        check("post_rst_lockout", {31'h0, o}, 32'h0);
        check("post_rst_no_req", 32'(rv_cnt - rv0), 32'd0);
        check("post_rst_no_oe", 32'(oe_cnt - oe0), 32'd0);
        line_reset();
        run_txn(vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
